// File: rtl/ccip_add_seq_pkg.sv
// Shared types and constants for the CCI-P read-read-add-write sequencer.
package ccip_add_seq_pkg;

    // Controller states; the encoding width is fixed at 3 bits
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRdA    = 3'd1,
        StRdB    = 3'd2,
        StWaitRd = 3'd3,
        StWr     = 3'd4,
        StWaitWr = 3'd5
    } t_add_seq_state;

    // Read tags identifying which operand a c0 response carries
    localparam logic [15:0] ADD_SEQ_TAG_A = 16'h0000;
    localparam logic [15:0] ADD_SEQ_TAG_B = 16'h0001;

    localparam int unsigned ADD_SEQ_ADDR_W = 42;
    localparam int unsigned ADD_SEQ_WORD_W = 64;
    localparam int unsigned ADD_SEQ_LINE_W = 512;

    // Result cache line: 64-bit sum in the low word, carry just above, zero pad on top
    typedef struct packed {
        logic [ADD_SEQ_LINE_W-ADD_SEQ_WORD_W-2:0] pad;
        logic                                     carry;
        logic [ADD_SEQ_WORD_W-1:0]                sum;
    } t_add_seq_result;

    // Place a 65-bit sum into the result line layout
    function automatic t_add_seq_result add_seq_pack(input logic [ADD_SEQ_WORD_W:0] s);
        t_add_seq_result res;
        res.pad   = '0;
        res.carry = s[ADD_SEQ_WORD_W];
        res.sum   = s[ADD_SEQ_WORD_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/ccip_add_seq_watchdog.sv
// Wait-state watchdog: counts cycles while enabled, flags expiry at TIMEOUT_CYCLES-1.
// Only instantiated when CCIP_ADD_SEQ_TIMEOUT_EN is defined.
module ccip_add_seq_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] r_count;

    // Cycle counter; saturates at the expiry value so it never wraps
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LastCnt)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_enable && (r_count == LastCnt);

endmodule

// File: rtl/ccip_add_sequencer.sv
// Sequences one read A / read B / add / write transaction over CCI-P c0 and c1.
// Optional wait-state timeout is enabled by defining CCIP_ADD_SEQ_TIMEOUT_EN.
module ccip_add_sequencer
    import ccip_add_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [41:0]  src_addr,
    input  logic [41:0]  dst_addr,
    input  logic         c0TxAlmFull,
    input  logic         c1TxAlmFull,
    output logic         rd_req_valid,
    output logic [41:0]  rd_req_addr,
    output logic [15:0]  rd_req_mdata,
    input  logic         rd_rsp_valid,
    input  logic [15:0]  rd_rsp_mdata,
    input  logic [511:0] rd_rsp_data,
    output logic         wr_req_valid,
    output logic [41:0]  wr_req_addr,
    output logic [511:0] wr_req_data,
    input  logic         wr_rsp_valid,
    output logic         busy,
    output logic         done,
    output logic         error
);

    t_add_seq_state  r_state, w_state_d;
    logic [41:0]     r_src, w_src_d;
    logic [41:0]     r_dst, w_dst_d;
    logic [63:0]     r_op_a, w_op_a_d;
    logic [63:0]     r_op_b, w_op_b_d;
    logic            r_has_a, w_has_a_d;
    logic            r_has_b, w_has_b_d;
    logic [64:0]     r_sum, w_sum_d;
    logic            r_rd_valid, w_rd_valid_d;
    logic [41:0]     r_rd_addr, w_rd_addr_d;
    logic [15:0]     r_rd_mdata, w_rd_mdata_d;
    logic            r_wr_valid, w_wr_valid_d;
    logic [41:0]     r_wr_addr, w_wr_addr_d;
    t_add_seq_result r_wr_data, w_wr_data_d;
    logic            r_busy, w_busy_d;
    logic            r_done, w_done_d;
    logic            w_capture;

    // A operand response may land before B is issued, so capture spans RD_B and WAIT_RD
    assign w_capture = rd_rsp_valid && ((r_state == StRdB) || (r_state == StWaitRd));

`ifdef CCIP_ADD_SEQ_TIMEOUT_EN
    logic r_error, w_error_d;
    logic w_in_wait;
    logic w_expire;

    // Counter is held clear outside the wait states, so it restarts on each entry
    assign w_in_wait = (r_state == StWaitRd) || (r_state == StWaitWr);

    ccip_add_seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk    (clk),
        .i_rst_n  (reset_n),
        .i_clear  (!w_in_wait),
        .i_enable (w_in_wait),
        .o_expire (w_expire)
    );
`endif

    // Next-state, operand capture and registered-output next values
    always_comb begin
        w_state_d    = r_state;
        w_src_d      = r_src;
        w_dst_d      = r_dst;
        w_op_a_d     = r_op_a;
        w_op_b_d     = r_op_b;
        w_has_a_d    = r_has_a;
        w_has_b_d    = r_has_b;
        w_sum_d      = r_sum;
        w_rd_valid_d = 1'b0;
        w_rd_addr_d  = r_rd_addr;
        w_rd_mdata_d = r_rd_mdata;
        w_wr_valid_d = 1'b0;
        w_wr_addr_d  = r_wr_addr;
        w_wr_data_d  = r_wr_data;
        w_done_d     = 1'b0;
`ifdef CCIP_ADD_SEQ_TIMEOUT_EN
        w_error_d    = 1'b0;
`endif

        // First response per tag wins; unknown tags and repeats are dropped
        if (w_capture) begin
            if ((rd_rsp_mdata == ADD_SEQ_TAG_A) && !r_has_a) begin
                w_op_a_d  = rd_rsp_data[63:0];
                w_has_a_d = 1'b1;
            end else if ((rd_rsp_mdata == ADD_SEQ_TAG_B) && !r_has_b) begin
                w_op_b_d  = rd_rsp_data[63:0];
                w_has_b_d = 1'b1;
            end
        end

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_src_d   = src_addr;
                    w_dst_d   = dst_addr;
                    w_has_a_d = 1'b0;
                    w_has_b_d = 1'b0;
                    w_state_d = StRdA;
                end
            end
            StRdA: begin
                if (!c0TxAlmFull) begin
                    w_rd_valid_d = 1'b1;
                    w_rd_addr_d  = r_src;
                    w_rd_mdata_d = ADD_SEQ_TAG_A;
                    w_state_d    = StRdB;
                end
            end
            StRdB: begin
                if (!c0TxAlmFull) begin
                    w_rd_valid_d = 1'b1;
                    w_rd_addr_d  = r_src + 42'd1;
                    w_rd_mdata_d = ADD_SEQ_TAG_B;
                    w_state_d    = StWaitRd;
                end
            end
            StWaitRd: begin
                if (r_has_a && r_has_b) begin
                    w_sum_d   = {1'b0, r_op_a} + {1'b0, r_op_b};
                    w_state_d = StWr;
                end
`ifdef CCIP_ADD_SEQ_TIMEOUT_EN
                else if (w_expire) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                    w_error_d = 1'b1;
                end
`endif
            end
            StWr: begin
                if (!c1TxAlmFull) begin
                    w_wr_valid_d = 1'b1;
                    w_wr_addr_d  = r_dst;
                    w_wr_data_d  = add_seq_pack(r_sum);
                    w_state_d    = StWaitWr;
                end
            end
            StWaitWr: begin
                if (wr_rsp_valid) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end
`ifdef CCIP_ADD_SEQ_TIMEOUT_EN
                else if (w_expire) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                    w_error_d = 1'b1;
                end
`endif
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // busy tracks the next state so it drops in the same cycle done pulses
        w_busy_d = (w_state_d != StIdle);
    end

    // State, datapath and output registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_src      <= '0;
            r_dst      <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_has_a    <= 1'b0;
            r_has_b    <= 1'b0;
            r_sum      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_mdata <= '0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_src      <= w_src_d;
            r_dst      <= w_dst_d;
            r_op_a     <= w_op_a_d;
            r_op_b     <= w_op_b_d;
            r_has_a    <= w_has_a_d;
            r_has_b    <= w_has_b_d;
            r_sum      <= w_sum_d;
            r_rd_valid <= w_rd_valid_d;
            r_rd_addr  <= w_rd_addr_d;
            r_rd_mdata <= w_rd_mdata_d;
            r_wr_valid <= w_wr_valid_d;
            r_wr_addr  <= w_wr_addr_d;
            r_wr_data  <= w_wr_data_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
        end
    end

`ifdef CCIP_ADD_SEQ_TIMEOUT_EN
    // Error flag accompanies done for one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_error <= 1'b0;
        end else begin
            r_error <= w_error_d;
        end
    end

    assign error = r_error;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
    assign error        = 1'b0;
`endif

    // Only the low word of each response line is an operand
    logic w_unused_rsp;
    assign w_unused_rsp = ^rd_rsp_data[511:64];

    assign rd_req_valid = r_rd_valid;
    assign rd_req_addr  = r_rd_addr;
    assign rd_req_mdata = r_rd_mdata;
    assign wr_req_valid = r_wr_valid;
    assign wr_req_addr  = r_wr_addr;
    assign wr_req_data  = r_wr_data;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_ccip_add_sequencer.sv
// Scoreboard bench for ccip_add_sequencer: stimulus pushes expected reads, writes and
// completions; a negedge monitor pops and compares whenever the DUT presents them.
module tb_ccip_add_sequencer;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [41:0]  src_addr;
    logic [41:0]  dst_addr;
    logic         c0TxAlmFull;
    logic         c1TxAlmFull;
    logic         rd_req_valid;
    logic [41:0]  rd_req_addr;
    logic [15:0]  rd_req_mdata;
    logic         rd_rsp_valid;
    logic [15:0]  rd_rsp_mdata;
    logic [511:0] rd_rsp_data;
    logic         wr_req_valid;
    logic [41:0]  wr_req_addr;
    logic [511:0] wr_req_data;
    logic         wr_rsp_valid;
    logic         busy;
    logic         done;
    logic         error;

    ccip_add_sequencer #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .c0TxAlmFull  (c0TxAlmFull),
        .c1TxAlmFull  (c1TxAlmFull),
        .rd_req_valid (rd_req_valid),
        .rd_req_addr  (rd_req_addr),
        .rd_req_mdata (rd_req_mdata),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_mdata (rd_rsp_mdata),
        .rd_rsp_data  (rd_rsp_data),
        .wr_req_valid (wr_req_valid),
        .wr_req_addr  (wr_req_addr),
        .wr_req_data  (wr_req_data),
        .wr_rsp_valid (wr_rsp_valid),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tot = 0;
    int bad = 0;

    logic [57:0]  exp_rd[$];    // {addr, tag}
    logic [553:0] exp_wr[$];    // {addr, line}
    logic         exp_done[$];  // expected error flag
    logic [15:0]  q_seen[$];
    int           rd_cnt = 0;
    int           wr_cnt = 0;
    int           done_cnt = 0;
    int           n_rd_exp = 0;
    int           n_wr_exp = 0;

    logic c0_prev = 1'b0;
    logic c1_prev = 1'b0;

    task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] req);
        tot++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic fail(input string nm);
        tot++;
        bad++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Almost-full as seen by the DUT at the edge that produced the current outputs
    always @(posedge clk) begin
        c0_prev <= c0TxAlmFull;
        c1_prev <= c1TxAlmFull;
    end

    // Monitor: pop and compare whenever the DUT presents a request or completion
    logic [57:0]  m_rd;
    logic [553:0] m_wr;
    logic         m_err;
    always @(negedge clk) begin
        if (reset_n) begin
            if (rd_req_valid) begin
                chk("rd_almfull_honoured", 576'(c0_prev), 576'(0));
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", 576'({rd_req_addr, rd_req_mdata}), 576'(0) - 1);
                end else begin
                    m_rd = exp_rd.pop_front();
                    chk("rd_req", 576'({rd_req_addr, rd_req_mdata}), 576'(m_rd));
                end
                q_seen.push_back(rd_req_mdata);
                rd_cnt++;
            end
            if (wr_req_valid) begin
                chk("wr_almfull_honoured", 576'(c1_prev), 576'(0));
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 576'({wr_req_addr, wr_req_data}), 576'(0) - 1);
                end else begin
                    m_wr = exp_wr.pop_front();
                    chk("wr_req", 576'({wr_req_addr, wr_req_data}), 576'(m_wr));
                end
                wr_cnt++;
            end
            if (done) begin
                chk("done_busy_low", 576'(busy), 576'(0));
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", 576'(done), 576'(0));
                end else begin
                    m_err = exp_done.pop_front();
                    chk("done_error", 576'(error), 576'(m_err));
                end
                done_cnt++;
            end
        end
    end

    function automatic logic [41:0] rnd_addr();
        logic [9:0]  hi;
        logic [31:0] lo;
        hi = 10'($urandom_range(0, 1023));
        lo = $urandom;
        return {hi, lo};
    endfunction

    function automatic logic [63:0] rnd_word();
        logic [31:0] hi;
        logic [31:0] lo;
        hi = $urandom;
        lo = $urandom;
        return {hi, lo};
    endfunction

    // One-cycle read response; upper bits of the line are random filler
    task automatic send_rsp(input logic [15:0] tag, input logic [63:0] val);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        d[63:0]      = val;
        rd_rsp_valid = 1'b1;
        rd_rsp_mdata = tag;
        rd_rsp_data  = d;
        step();
        rd_rsp_valid = 1'b0;
    endtask

    task automatic wait_seen(input string nm);
        int k;
        k = 0;
        while (q_seen.size() == 0 && k < 60) begin
            step();
            k++;
        end
        if (q_seen.size() == 0) fail(nm);
        else void'(q_seen.pop_front());
    endtask

    // Reference model: expected reads of src and src+1, one write of the 65-bit sum
    task automatic expect_txn(input logic [41:0] src, input logic [41:0] dst,
                              input logic [63:0] a, input logic [63:0] b, input bit with_wr);
        logic [41:0]  src_b;
        logic [64:0]  s;
        logic [511:0] line;
        src_b = src + 42'd1;
        s     = {1'b0, a} + {1'b0, b};
        line  = 512'(s);
        exp_rd.push_back({src, 16'h0000});
        exp_rd.push_back({src_b, 16'h0001});
        n_rd_exp += 2;
        if (with_wr) begin
            exp_wr.push_back({dst, line});
            exp_done.push_back(1'b0);
            n_wr_exp++;
        end
    endtask

    task automatic pulse_start(input logic [41:0] src, input logic [41:0] dst);
        src_addr = src;
        dst_addr = dst;
        start    = 1'b1;
        step();
        start    = 1'b0;
        src_addr = rnd_addr();
        dst_addr = rnd_addr();
    endtask

    task automatic run_txn(input logic [41:0] src, input logic [41:0] dst,
                           input logic [63:0] a, input logic [63:0] b, input bit rev,
                           input int c0_bp, input int c1_bp, input bit noise);
        int w0;
        int d0;
        int k;
        q_seen.delete();
        expect_txn(src, dst, a, b, 1'b1);
        w0 = wr_cnt;
        d0 = done_cnt;
        pulse_start(src, dst);
        chk("busy_rise", 576'(busy), 576'(1));
        if (c0_bp > 0) begin
            c0TxAlmFull = 1'b1;
            repeat (c0_bp) step();
            c0TxAlmFull = 1'b0;
        end
        wait_seen("rd_a_wait");
        if (noise) pulse_start(rnd_addr(), rnd_addr());
        if (!rev) begin
            send_rsp(16'h0000, a);
            if (noise) begin
                send_rsp(16'h0002, ~b);
                send_rsp(16'h0000, ~a);
            end
        end
        wait_seen("rd_b_wait");
        if (c1_bp > 0) c1TxAlmFull = 1'b1;
        if (rev) begin
            send_rsp(16'h0001, b);
            send_rsp(16'h0000, a);
        end else begin
            send_rsp(16'h0001, b);
        end
        if (c1_bp > 0) begin
            repeat (c1_bp + 2) step();
            c1TxAlmFull = 1'b0;
        end
        k = 0;
        while (wr_cnt == w0 && k < 60) begin
            step();
            k++;
        end
        if (wr_cnt == w0) fail("wr_wait");
        repeat ($urandom_range(0, 2)) step();
        wr_rsp_valid = 1'b1;
        step();
        wr_rsp_valid = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 20) begin
            step();
            k++;
        end
        if (done_cnt == d0) fail("done_wait");
        step();
    endtask

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        src_addr     = '0;
        dst_addr     = '0;
        c0TxAlmFull  = 1'b0;
        c1TxAlmFull  = 1'b0;
        rd_rsp_valid = 1'b0;
        rd_rsp_mdata = '0;
        rd_rsp_data  = '0;
        wr_rsp_valid = 1'b0;

        repeat (3) step();
        chk("rst_outputs",
            576'({rd_req_valid, wr_req_valid, busy, done, error, rd_req_addr, rd_req_mdata,
                  wr_req_addr}), 576'(0));
        chk("rst_wr_data", 576'(wr_req_data), 576'(0));
        reset_n = 1'b1;
        step();

        // Basic in-order add
        run_txn(42'h100, 42'h2000, 64'h5, 64'h7, 1'b0, 0, 0, 1'b0);
        // Carry out with B responding before A
        run_txn(42'h3ff0, 42'h55, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 0, 0, 1'b0);
        // Back-pressure on both channels
        run_txn(rnd_addr(), rnd_addr(), rnd_word(), rnd_word(), 1'b0, 10, 5, 1'b0);
        // Dropped start, unknown tag and duplicate A
        run_txn(rnd_addr(), rnd_addr(), 64'h1234, 64'h8765_0000_0000_0000, 1'b0, 0, 0, 1'b1);

        // Reset while waiting on read responses, then stale responses arrive
        begin
            int w0;
            logic [41:0] src;
            src = rnd_addr();
            q_seen.delete();
            expect_txn(src, 42'h9, 64'h11, 64'h22, 1'b0);
            w0 = wr_cnt;
            pulse_start(src, 42'h9);
            wait_seen("rst_rd_a");
            wait_seen("rst_rd_b");
            step();
            #2 reset_n = 1'b0;
            #1;
            chk("rst_mid_busy", 576'({busy, rd_req_valid, wr_req_valid, done}), 576'(0));
            chk("rst_mid_rd_addr", 576'({rd_req_addr, rd_req_mdata}), 576'(0));
            step();
            reset_n = 1'b1;
            send_rsp(16'h0000, 64'h11);
            send_rsp(16'h0001, 64'h22);
            repeat (8) step();
            chk("rst_stays_idle", 576'(busy), 576'(0));
            chk("rst_no_write", 576'(wr_cnt), 576'(w0));
        end
        run_txn(42'h777, 42'h888, 64'h40, 64'h2, 1'b0, 0, 0, 1'b0);

        // Operand B address wraps to zero
        run_txn('1, 42'h1, rnd_word(), rnd_word(), 1'b1, 0, 0, 1'b0);

        // Randomized transactions
        for (int i = 0; i < 12; i++) begin
            logic [63:0] a;
            logic [63:0] b;
            a = rnd_word();
            b = rnd_word();
            if ($urandom_range(0, 3) == 0) a = '1;
            run_txn(rnd_addr(), rnd_addr(), a, b, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

`ifdef CCIP_ADD_SEQ_TIMEOUT_EN
        // Withheld read responses: abort with error 16 cycles after entering WAIT_RD
        begin
            int d0;
            int w0;
            int k;
            q_seen.delete();
            expect_txn(42'h40, 42'h50, 64'h0, 64'h0, 1'b0);
            exp_done.push_back(1'b1);
            d0 = done_cnt;
            w0 = wr_cnt;
            pulse_start(42'h40, 42'h50);
            wait_seen("to_rd_a");
            while (q_seen.size() == 0 && k < 20) begin
                step();
                k++;
            end
            void'(q_seen.pop_front());
            k = 0;
            while (done_cnt == d0 && k < 100) begin
                step();
                k++;
            end
            chk("timeout_cycles", 576'(k), 576'(16));
            chk("timeout_no_write", 576'(wr_cnt), 576'(w0));
            step();
        end
`endif

        repeat (4) step();
        chk("rd_queue_drained", 576'(exp_rd.size()), 576'(0));
        chk("wr_queue_drained", 576'(exp_wr.size()), 576'(0));
        chk("done_queue_drained", 576'(exp_done.size()), 576'(0));
        chk("rd_total", 576'(rd_cnt), 576'(n_rd_exp));
        chk("wr_total", 576'(wr_cnt), 576'(n_wr_exp));

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
